// File: rtl/apb_cmd_executor_if.sv
// APB request/response bundle between the command executor (master) and the
// addressed completer (slave).
interface apb_cmd_executor_if;
   logic [7:0]  paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output paddr, psel, penable, pwrite, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_cmd_executor.sv
// Pops 48-bit commands from a FIFO, runs each as one APB transfer with a
// wait-state timeout, and pushes one 48-bit response per command.
module apb_cmd_executor #(
   parameter int RAH_PACKET_WIDTH = 48,
   parameter int TIMEOUT_CYCLES   = 255
) (
   input  logic                        dt_clk,
   input  logic                        rst,
   input  logic                        f_empty,
   input  logic [RAH_PACKET_WIDTH-1:0] f_data,
   output logic                        f_rd_en,
   apb_cmd_executor_if.master          apb,
   input  logic                        pp_rd_fifo_full,
   output logic                        pp_rd_fifo_en,
   output logic [RAH_PACKET_WIDTH-1:0] pp_rd_fifo_data,
   output logic                        busy,
   output logic                        timeout_o
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LATCH,
      SETUP,
      ACCESS,
      RESP
   } state_t;

   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

   state_t      state;
   state_t      state_nxt;
   logic        cmd_write;
   logic [6:0]  cmd_tag;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [7:0]  to_cnt;
   logic        acc_done;
   logic        acc_abort;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Completion has priority over abort when pready arrives on the limit cycle.
   assign acc_done  = (state == ACCESS) && apb.pready;
   assign acc_abort = (state == ACCESS) && !apb.pready && (sat_inc(to_cnt) >= TO_LIMIT);

   assign apb.paddr  = cmd_addr;
   assign apb.pwrite = cmd_write;
   assign apb.pwdata = cmd_wdata;
   assign busy       = (state != IDLE);

   always_ff @(posedge dt_clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      f_rd_en       = 1'b0;
      apb.psel      = 1'b0;
      apb.penable   = 1'b0;
      pp_rd_fifo_en = 1'b0;
      timeout_o     = 1'b0;
      unique case (state)
         IDLE: begin
            if (!f_empty) state_nxt = FETCH;
         end
         FETCH: begin
            f_rd_en   = 1'b1;
            state_nxt = LATCH;
         end
         LATCH: begin
            state_nxt = SETUP;
         end
         SETUP: begin
            apb.psel  = 1'b1;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            apb.psel    = 1'b1;
            apb.penable = 1'b1;
            if (acc_done) begin
               state_nxt = RESP;
            end else if (acc_abort) begin
               timeout_o = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (!pp_rd_fifo_full) begin
               pp_rd_fifo_en = 1'b1;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FIFO read data is valid the cycle after the pop, i.e. while in LATCH.
   always_ff @(posedge dt_clk or posedge rst) begin
      if (rst) begin
         cmd_write <= 1'b0;
         cmd_tag   <= '0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
      end else if (state == LATCH) begin
         {cmd_write, cmd_tag, cmd_addr, cmd_wdata} <= f_data[47:0];
      end
   end

   // Cleared while entering SETUP so each transfer gets a fresh wait budget.
   always_ff @(posedge dt_clk or posedge rst) begin
      if (rst) begin
         to_cnt <= '0;
      end else if (state == LATCH) begin
         to_cnt <= '0;
      end else if ((state == ACCESS) && !apb.pready) begin
         to_cnt <= sat_inc(to_cnt);
      end
   end

   always_ff @(posedge dt_clk or posedge rst) begin
      if (rst) begin
         pp_rd_fifo_data <= '0;
      end else if (acc_done) begin
         pp_rd_fifo_data <= {apb.pslverr, cmd_tag, cmd_addr, cmd_write ? 32'h0 : apb.prdata};
      end else if (acc_abort) begin
         pp_rd_fifo_data <= {1'b1, cmd_tag, cmd_addr, 32'h0};
      end
   end

endmodule

// File: doc/apb_cmd_executor.md
APB_CMD_EXECUTOR -- requirements
Module: apb_cmd_executor

Interface
REQ-001 SHALL have parameter RAH_PACKET_WIDTH, default 48, meaning command/response packet width (only 48 supported).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning maximum ACCESS cycles without pready before abort (range 1..255).
REQ-003 SHALL have port dt_clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port f_empty, input, 1, command FIFO empty.
REQ-006 SHALL have port f_data, input, RAH_PACKET_WIDTH, command FIFO read data, valid the cycle after f_rd_en.
REQ-007 SHALL have port f_rd_en, output, 1, command FIFO pop strobe.
REQ-008 SHALL have ports paddr (output, 8), psel (output, 1), penable (output, 1), pwrite (output, 1) and pwdata (output, 32), forming the APB request.
REQ-009 SHALL have ports prdata (input, 32), pready (input, 1) and pslverr (input, 1), forming the APB completer response.
REQ-010 SHALL have port pp_rd_fifo_full, input, 1, response FIFO full.
REQ-011 SHALL have port pp_rd_fifo_en, output, 1, response FIFO write strobe.
REQ-012 SHALL have port pp_rd_fifo_data, output, RAH_PACKET_WIDTH, response packet.
REQ-013 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-014 SHALL have port timeout_o, output, 1, one-cycle pulse on transaction abort.

Function
REQ-015 Command packet layout SHALL be: [47] write, [46:40] tag, [39:32] addr, [31:0] wdata.
REQ-016 Response packet layout SHALL be: [47] err, [46:40] tag, [39:32] addr, [31:0] rdata.
REQ-017 Response rdata SHALL be forced to 0 for writes and for aborted transactions.
REQ-018 FSM states SHALL be IDLE, FETCH, LATCH, SETUP, ACCESS and RESP.
REQ-019 From IDLE, the FSM SHALL go to FETCH when f_empty=0, and otherwise remain in IDLE.
REQ-020 In FETCH, f_rd_en SHALL be 1 for exactly one cycle, and the FSM SHALL then go to LATCH unconditionally.
REQ-021 f_rd_en SHALL be 0 in every state other than FETCH.
REQ-022 In LATCH, the FSM SHALL register f_data into internal command registers and then go to SETUP.
REQ-023 In SETUP: psel=1, penable=0, with paddr/pwrite/pwdata driven from the command registers; the next state SHALL be ACCESS.
REQ-024 In ACCESS: psel=1, penable=1, and the timeout counter SHALL increment each cycle while pready=0.
REQ-025 In ACCESS with pready=1, the FSM SHALL capture err=pslverr and rdata=prdata (reads only), then go to RESP.
REQ-026 In ACCESS, if the counter reaches TIMEOUT_CYCLES with pready still 0, the FSM SHALL set err=1, pulse timeout_o, and go to RESP.
REQ-027 If pready=1 in the same cycle the counter reaches TIMEOUT_CYCLES, the completion SHALL win: no timeout_o, and err=pslverr.
REQ-028 paddr, pwrite and pwdata SHALL stay stable from SETUP through the last ACCESS cycle.
REQ-029 psel and penable SHALL be 0 in IDLE, FETCH, LATCH and RESP.
REQ-030 Minimum APB transfer SHALL be 2 cycles (SETUP plus one ACCESS); a zero-wait transaction from f_empty falling to pp_rd_fifo_en SHALL take 5 cycles.
REQ-031 In RESP, while pp_rd_fifo_full=1, the FSM SHALL hold, with pp_rd_fifo_en=0 and pp_rd_fifo_data stable.
REQ-032 In RESP, when pp_rd_fifo_full=0, pp_rd_fifo_en SHALL be 1 for one cycle, and the FSM SHALL go to IDLE.
REQ-033 Every popped command SHALL produce exactly one response; no command SHALL be dropped or duplicated.
REQ-034 There SHALL be no pipelining: the next FETCH occurs no earlier than the cycle after RESP completes.
REQ-035 pslverr SHALL be sampled only when psel=1, penable=1 and pready=1.
REQ-036 The timeout counter SHALL be 8 bits, SHALL clear on entry to SETUP, and SHALL saturate (no wrap).

Reset
REQ-037 On assertion of rst: state=IDLE, and f_rd_en, psel, penable, pwrite, pp_rd_fifo_en, busy and timeout_o SHALL all be 0.
REQ-038 On assertion of rst: paddr=0, pwdata=0, pp_rd_fifo_data=0, the command registers=0, and the counter=0.
REQ-039 Reset mid-transaction (including during ACCESS) SHALL abandon the transaction immediately, with no response written.
REQ-040 Reset SHALL be released synchronously to dt_clk; the first FETCH SHALL occur no earlier than the first clock edge after deassertion.

Verification
REQ-041 Write, zero-wait: f_data=0x85_12_DEADBEEF, pready=1 in ACCESS, pslverr=0 -> APB write to addr 0x12 with pwdata 0xDEADBEEF; response 0x05_12_00000000, 5 cycles after f_empty falls.
REQ-042 Read, 3 wait states: f_data=0x03_40_00000000, prdata=0xCAFEF00D -> ACCESS lasts 4 cycles; response 0x03_40_CAFEF00D.
REQ-043 Timeout with TIMEOUT_CYCLES=4 and pready held 0 -> timeout_o pulses once after 4 ACCESS cycles; response has err=1 and rdata=0; psel drops.
REQ-044 Back-pressure: pp_rd_fifo_full=1 for 10 cycles during RESP -> no pp_rd_fifo_en, data stable, no f_rd_en; exactly one write after full clears.
REQ-045 Reset mid-ACCESS -> all outputs 0 within the same cycle; no response; the next queued command executes normally after release.
REQ-046 pslverr=1 on a read -> response err=1 with rdata=prdata; 8 back-to-back commands yield 8 responses in order, with tags matching.
